// File: rtl/frog_game_state_if.sv
// Frog game pins: VGA vsync and raw buttons in, grid positions and game status out.
interface frog_game_state_if;
    logic       vsync;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [3:0] player_x;
    logic [3:0] player_y;
    logic [3:0] car_x;
    logic [3:0] car_y;
    logic [1:0] lives;
    logic [7:0] score;
    logic       hit;
    logic       game_over;

    modport master (
        output vsync, btn_up, btn_down, btn_left, btn_right,
        input  player_x, player_y, car_x, car_y, lives, score, hit, game_over
    );

    modport slave (
        input  vsync, btn_up, btn_down, btn_left, btn_right,
        output player_x, player_y, car_x, car_y, lives, score, hit, game_over
    );
endinterface

// File: rtl/frog_game_state.sv
// Frog game-state engine: button moves, car motion, collision/goal, lives and score.
// All visible state changes on the edge closing the vsync-falling frame tick; outputs registered.
module frog_game_state #(
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 12,
    parameter int START_X    = 7,
    parameter int START_Y    = 11,
    parameter int CAR_ROW    = 5,
    parameter int CAR_PERIOD = 8,
    parameter int HIT_FRAMES = 30,
    parameter int LIVES      = 3
) (
    input  logic               clk,
    input  logic               rst,
    frog_game_state_if.slave   bus
);
    localparam int FC_W = (CAR_PERIOD > 1) ? $clog2(CAR_PERIOD) : 1;
    localparam int HC_W = $clog2(HIT_FRAMES + 1);

    typedef enum logic [1:0] {ST_PLAY, ST_HIT, ST_OVER} state_e;
    typedef enum logic [1:0] {MV_UP, MV_DOWN, MV_LEFT, MV_RIGHT} move_e;

    state_e            state_q, state_d;
    move_e             pend_dir_q, pend_dir_d;
    logic              pend_vld_q, pend_vld_d;
    logic [3:0]        px_q, px_d, py_q, py_d, cx_q, cx_d;
    logic [1:0]        lives_q, lives_d;
    logic [7:0]        score_q, score_d;
    logic [FC_W-1:0]   fc_q, fc_d;
    logic [HC_W-1:0]   hc_q, hc_d;
    logic              vsync_q;
    logic [3:0]        btn_s1_q, btn_s2_q, btn_prev_q;
    logic [3:0]        btn_raw, press;
    logic              frame_tick;
    logic [3:0]        mx, my;

    // Bit order gives the priority up > down > left > right.
    assign btn_raw    = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    assign press      = btn_s2_q & ~btn_prev_q;
    assign frame_tick = vsync_q & ~bus.vsync;

    always_comb begin
        state_d    = state_q;
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        px_d       = px_q;
        py_d       = py_q;
        cx_d       = cx_q;
        lives_d    = lives_q;
        score_d    = score_q;
        fc_d       = fc_q;
        hc_d       = hc_q;
        mx         = px_q;
        my         = py_q;

        if (state_q != ST_PLAY || frame_tick) begin
            pend_vld_d = 1'b0;
        end else if (!pend_vld_q && |press) begin
            pend_vld_d = 1'b1;
            if (press[0])      pend_dir_d = MV_UP;
            else if (press[1]) pend_dir_d = MV_DOWN;
            else if (press[2]) pend_dir_d = MV_LEFT;
            else               pend_dir_d = MV_RIGHT;
        end

        if (frame_tick && state_q != ST_OVER) begin
            if (fc_q == FC_W'(CAR_PERIOD - 1)) begin
                fc_d = '0;
                cx_d = (cx_q == 4'(GRID_W - 1)) ? 4'd0 : cx_q + 4'd1;
            end else begin
                fc_d = fc_q + FC_W'(1);
            end

            if (pend_vld_q) begin
                case (pend_dir_q)
                    MV_UP:    if (py_q != 4'd0)            my = py_q - 4'd1;
                    MV_DOWN:  if (py_q != 4'(GRID_H - 1))  my = py_q + 4'd1;
                    MV_LEFT:  if (px_q != 4'd0)            mx = px_q - 4'd1;
                    default:  if (px_q != 4'(GRID_W - 1))  mx = px_q + 4'd1;
                endcase
            end

            case (state_q)
                ST_PLAY: begin
                    // Collision uses post-tick positions of both player and car.
                    if (mx == cx_d && my == 4'(CAR_ROW)) begin
                        px_d    = 4'(START_X);
                        py_d    = 4'(START_Y);
                        lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                        if (lives_q <= 2'd1) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_HIT;
                            hc_d    = HC_W'(HIT_FRAMES);
                        end
                    end else if (my == 4'd0) begin
                        px_d    = 4'(START_X);
                        py_d    = 4'(START_Y);
                        score_d = (score_q == 8'hff) ? score_q : score_q + 8'd1;
                    end else begin
                        px_d = mx;
                        py_d = my;
                    end
                end
                ST_HIT: begin
                    hc_d = hc_q - HC_W'(1);
                    if (hc_q == HC_W'(1)) state_d = ST_PLAY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_PLAY;
            pend_vld_q <= 1'b0;
            pend_dir_q <= MV_UP;
            px_q       <= 4'(START_X);
            py_q       <= 4'(START_Y);
            cx_q       <= 4'd0;
            lives_q    <= 2'(LIVES);
            score_q    <= 8'd0;
            fc_q       <= '0;
            hc_q       <= '0;
            vsync_q    <= 1'b0;
            btn_s1_q   <= 4'd0;
            btn_s2_q   <= 4'd0;
            btn_prev_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
            px_q       <= px_d;
            py_q       <= py_d;
            cx_q       <= cx_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            fc_q       <= fc_d;
            hc_q       <= hc_d;
            vsync_q    <= bus.vsync;
            btn_s1_q   <= btn_raw;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
        end
    end

    assign bus.player_x  = px_q;
    assign bus.player_y  = py_q;
    assign bus.car_x     = cx_q;
    assign bus.car_y     = 4'(CAR_ROW);
    assign bus.lives     = lives_q;
    assign bus.score     = score_q;
    assign bus.hit       = (state_q == ST_HIT);
    assign bus.game_over = (state_q == ST_OVER);
endmodule
